// File: rtl/program_memory_pipe.sv
// Pipelined program memory: zero-fill after reset, fixed two-cycle fetch latency, in-system load port.
// Optional stored even-parity bit with a parity_err output when PROGMEM_PARITY_EN is defined.
module program_memory_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              addr_err,
    input  logic              load_start,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
`ifdef PROGMEM_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PROGMEM_PARITY_EN
    localparam int unsigned STORE_W = DATA_W + 1;
`else
    localparam int unsigned STORE_W = DATA_W;
`endif

    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("program_memory_pipe: DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W");
    end

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        LOAD  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [IDX_W-1:0]    clr_cnt;

    logic [STORE_W-1:0]  mem [DEPTH];

    logic                s1_valid;
    logic [ADDR_W-1:0]   s1_addr;
    logic                rd_valid;
    logic                rd_err;
    logic [STORE_W-1:0]  rd_word;

    logic                accept_c;
    logic                clr_we_c;
    logic                ld_we_c;
    logic                mem_we_c;
    logic [IDX_W-1:0]    mem_waddr_c;
    logic [STORE_W-1:0]  mem_wdata_c;
    logic                s1_in_range_c;
    logic                ld_in_range_c;

    assign s1_in_range_c = (32'(s1_addr) < DEPTH);
    assign ld_in_range_c = (32'(load_addr) < DEPTH);

    // Next-state and per-cycle strobes
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        clr_we_c = 1'b0;
        ld_we_c  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we_c = 1'b1;
                if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                accept_c = fetch_req && fetch_ready;
                if (load_start) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid && !rd_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld_we_c = load_we && ld_in_range_c;
                if (load_done) begin
                    state_d = RUN;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Single write port shared by the zero-fill sweep and the loader
    always_comb begin
        mem_we_c    = clr_we_c || ld_we_c;
        mem_waddr_c = clr_we_c ? clr_cnt : IDX_W'(load_addr);
`ifdef PROGMEM_PARITY_EN
        mem_wdata_c = clr_we_c ? '0 : {^load_data, load_data};
`else
        mem_wdata_c = clr_we_c ? '0 : load_data;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= CLEAR;
            clr_cnt     <= '0;
            fetch_ready <= 1'b0;
            busy        <= 1'b1;
        end else begin
            state_q     <= state_d;
            fetch_ready <= (state_d == RUN);
            busy        <= (state_d != RUN);
            if (clr_we_c) begin
                clr_cnt <= clr_cnt + IDX_W'(1);
            end
        end
    end

    // Storage array with registered read port; intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
        if (s1_valid && s1_in_range_c) begin
            rd_word <= mem[IDX_W'(s1_addr)];
        end
    end

    // Fetch pipeline: address stage, memory read stage, output stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            rd_valid   <= 1'b0;
            rd_err     <= 1'b0;
            data_valid <= 1'b0;
            addr_err   <= 1'b0;
            data_out   <= '0;
        end else begin
            s1_valid   <= accept_c;
            if (accept_c) begin
                s1_addr <= fetch_addr;
            end
            rd_valid   <= s1_valid;
            rd_err     <= s1_valid && !s1_in_range_c;
            data_valid <= rd_valid;
            addr_err   <= rd_valid && rd_err;
            if (rd_valid) begin
                data_out <= rd_err ? '0 : rd_word[DATA_W-1:0];
            end
        end
    end

`ifdef PROGMEM_PARITY_EN
    // Stored word includes its parity bit, so any odd bit count flags corruption
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= rd_valid && !rd_err && (^rd_word);
        end
    end
`endif

endmodule

// File: doc/program_memory_pipe.md
# program_memory_pipe

Parametrised, pipelined program (instruction) memory for the simple processor: the next generation of the fixed 256×16 program memory. Serves instruction fetches through a request/valid handshake with fixed two-cycle latency. Zero-fills itself after reset and accepts in-system program loading through a dedicated load port, so a program can be installed without re-synthesis. Sits between the fetch stage and the (external) program loader.

## Interface
Parameters:
- DATA_W, 16, instruction word width
- ADDR_W, 8, address width
- DEPTH, 256, number of words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  fetch address
- fetch_ready  out  1  fetch accepted this cycle when fetch_req && fetch_ready
- data_out  out  DATA_W  fetched word
- data_valid  out  1  data_out valid (one-cycle pulse per accepted fetch)
- addr_err  out  1  qualifies data_valid: fetched address ≥ DEPTH
- load_start  in  1  pulse: request entry to LOAD mode
- load_we  in  1  write strobe (LOAD mode only)
- load_addr  in  ADDR_W  write address
- load_data  in  DATA_W  write data
- load_done  in  1  pulse: leave LOAD mode
- busy  out  1  high in CLEAR, DRAIN and LOAD

## Operation
- FSM states: CLEAR, RUN, DRAIN, LOAD.
- CLEAR (entered on reset): counter sweeps 0..DEPTH-1, writing 0, one word per cycle; then → RUN. fetch_ready=0; load_* ignored.
- RUN: fetch_ready=1. load_start → DRAIN (same cycle: the fetch accepted on that edge, if any, is still served).
- DRAIN: fetch_ready=0; waits until both pipeline stages are empty, then → LOAD. Minimum 1 cycle.
- LOAD: fetch_ready=0; load_we writes load_data to load_addr on the edge; load_addr ≥ DEPTH writes are dropped. load_done → RUN (a load_we in the same cycle still writes). load_done and load_start outside their states are ignored.
- Fetch pipeline: stage 1 registers address and valid; stage 2 registers memory read into data_out, sets data_valid, addr_err.
- Out-of-range fetch (addr ≥ DEPTH): data_out = 0, addr_err = 1, data_valid = 1.
- Back-to-back fetches accepted every cycle in RUN; no stalls, no output backpressure.
- No read/write collision possible: writes only occur when the pipeline is empty.

## Timing
- Reset values: fetch_ready=0, data_valid=0, addr_err=0, data_out=0, busy=1, state=CLEAR, sweep counter=0, pipeline valids=0. Memory array is not reset; CLEAR zero-fills it.
- Reset asserted mid-operation (any state): outputs take reset values immediately, in-flight fetches discarded, CLEAR restarts from 0 after release; loaded program lost.
- CLEAR duration: exactly DEPTH cycles after reset release; fetch_ready rises on cycle DEPTH+1.
- Fetch latency: accepted at edge N → data_valid high after edge N+2, for one cycle.
- data_out holds its last value when data_valid=0.
- DRAIN → LOAD on the first edge with both stages empty; busy stays high throughout.
- LOAD → RUN: fetch_ready high the cycle after load_done is sampled.

## Configuration
- PROGMEM_PARITY_EN: when defined, each word stores an extra even-parity bit computed on write (CLEAR writes parity 0); stage 2 recomputes parity and drives output port parity_err (1 bit, reset 0, qualified by data_valid, forced 0 on addr_err). When undefined, no parity bit is stored and the parity_err port does not exist.

## Test plan
- Reset release, DEPTH=256 -> busy=1 and fetch_ready=0 for 256 cycles; fetch of addr 0x05 afterwards returns 0x0000 two cycles after acceptance.
- load_start, write 0x1234@0, 0xABCD@1, 0x00FF@2, load_done; fetch 0,1,2 on consecutive cycles -> data_valid on 3 consecutive cycles with 0x1234, 0xABCD, 0x00FF.
- DEPTH=200; fetch 0xC8 -> data_valid=1, addr_err=1, data_out=0; load_we to 0xC8 -> no write, no effect on word 0.
- load_start asserted in the same cycle as accepted fetch of addr 1 -> that fetch still returns 0xABCD; fetch_ready=0 until load_done.
- rst pulsed low mid-LOAD after writing 0x5555@3 -> outputs reset immediately, CLEAR reruns, later fetch of 3 returns 0x0000.
- PROGMEM_PARITY_EN defined, force flip of stored bit at addr 0 -> parity_err=1 with data_valid; unmodified addr 1 -> parity_err=0.
